energy_window_ctrl: RTL and testbench
=====================================

# energy_window_ctrl

Windowed-energy controller and averager that drives the `int_start`/`int_stop` window of `energy_integrator` and consumes its `out_data`/`out_data_N` result. It counts accepted samples to close each window of programmable length. It then divides the accumulated signed energy by the true sample count to give mean power, using a sequential divider. It sits beside the integrator in the sample-generator path and presents one averaged result per window to the register/AXI side.

## Interface
- `REG_DATA_WIDTH`, 32: width of window length and sample count.
- `OUT_DATA_WIDTH`, 64: width of accumulated energy and averaged result.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `enable`  in  1  level; while high, windows run back-to-back.
- `window_len`  in  REG_DATA_WIDTH  samples per window; sampled at each window start; 0 is treated as 1.
- `in_data_valid`  in  1  same sample strobe that feeds the integrator.
- `int_start`  out  1  one-cycle pulse that opens a window.
- `int_stop`  out  1  one-cycle pulse that closes a window.
- `energy_in`  in  OUT_DATA_WIDTH  signed accumulated energy from the integrator.
- `energy_n_in`  in  REG_DATA_WIDTH  integrator count; this is samples+1 because the integrator count starts at 1.
- `energy_valid_in`  in  1  integrator result-valid level.
- `avg_out`  out  OUT_DATA_WIDTH  signed mean = energy / samples.
- `avg_n`  out  REG_DATA_WIDTH  samples in the window that produced `avg_out`.
- `avg_valid`  out  1  one-cycle pulse per result.
- `div_zero`  out  1  set together with `avg_valid` when samples = 0; `avg_out` = 0 in that case.
- `busy`  out  1  divider active.
- `overrun`  out  1  sticky; a result was dropped because the divider was busy.
- `clr_overrun`  in  1  clears `overrun`; the set condition wins if both occur in the same cycle.

## Operation
- **Reset values:** every output 0; window FSM in IDLE; divider FSM in DIV_IDLE.
- **Window FSM states and transitions:**
  - IDLE → START when `enable` = 1.
  - START: `int_start` = 1 for one cycle; latch `max(window_len, 1)`; clear the sample counter. Then → RUN.
  - RUN: count cycles with `in_data_valid` = 1. When a valid arrives with count = len−1, go to STOP.
  - STOP: `int_stop` = 1 for one cycle; arm capture. Then → START if `enable` = 1, else → IDLE.
- **Sample alignment with the integrator:**
  - Samples in the START cycle are not counted; the integrator enable is not yet set.
  - Samples in the STOP cycle are not counted; the integrator ignores samples while `int_stop` is high.
- **`enable` dropping in RUN:** the current window completes normally; no new window starts.
- **Capture:** in the cycle after STOP, if `energy_valid_in` = 1, latch `energy_in` and set samples = `energy_n_in` − 1.
  - If the divider is busy at that point, set `overrun` and drop the result.
  - If `energy_valid_in` = 0 in that cycle, also set `overrun`.
- **Divider:**
  - Takes the magnitude of the energy and performs an unsigned restoring division, one quotient bit per cycle, OUT_DATA_WIDTH iterations.
  - A final cycle applies the sign.
  - Quotient truncates toward zero; the remainder is discarded.
  - samples = 0 skips the division and produces `avg_out` = 0 with `div_zero` = 1.
- **Result outputs:** `avg_out` and `avg_n` hold until the next `avg_valid`.
- **Reset mid-window or mid-division:** everything aborts immediately, no pulses are issued, and all outputs return to 0.

## Timing
- `int_start` at cycle S opens the window.
- `int_stop` comes exactly one cycle after the cycle carrying the window_len-th valid sample counted from S+1.
- Capture occurs at STOP+1.
- `avg_valid` is asserted at capture + OUT_DATA_WIDTH + 2 for a normal divide (66 cycles at the default width).
- For samples = 0, `avg_valid` is asserted at capture + 1.
- `busy` is high from capture+1 through the cycle before `avg_valid`.
- Back-to-back windows: the next `int_start` is in the cycle after `int_stop`, which is the same cycle as capture.
  - Windows shorter than OUT_DATA_WIDTH+2 cycles therefore cause `overrun`.

## Configuration
- Macro `ENERGY_AVG_ROUND_EN`.
- **Defined:** (samples >> 1) is added to the dividend magnitude before dividing. The result rounds half away from zero. The divider datapath gains one bit; latency is unchanged.
- **Undefined:** truncation toward zero.

## Structure
- **Package `energy_pkg`:** default widths, window FSM state enum (IDLE/START/RUN/STOP), divider state enum (DIV_IDLE/DIV_RUN/DIV_SIGN/DIV_DONE).
- **Sub-module `seq_udivider`:** parameterised unsigned restoring divider with `start`/`done` handshake. The top level owns sign handling, the zero-divisor case and rounding.

## Test plan
- Window of 4 samples, energies 3,3,3,3 → `energy_in` = 12, `energy_n_in` = 5 → `avg_out` = 3, `avg_n` = 4, `avg_valid` at capture+66.
- Signed case: `energy_in` = −7, samples = 2 → `avg_out` = −3 truncated; with `ENERGY_AVG_ROUND_EN` → −4.
- `window_len` = 0 → behaves as 1; `int_stop` is one cycle after the first counted sample.
- `window_len` = 10 with `enable` held → second window's capture finds the divider busy → `overrun` = 1, first result still correct; `clr_overrun` clears it.
- `energy_n_in` = 1 (zero samples) → `avg_out` = 0, `div_zero` = 1, `avg_valid` at capture+1.
- `rst` asserted mid-division → immediate return to reset values; no `avg_valid` pulse.

Source files
------------

// File: rtl/energy_pkg.sv
// Shared definitions for the windowed-energy averager: default widths and
// the state encodings of the window and divider controllers.
package energy_pkg;

    localparam int REG_DATA_WIDTH_DEF = 32;
    localparam int OUT_DATA_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } win_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_SIGN = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_udivider.sv
// Unsigned restoring divider, one quotient bit per cycle, DW iterations.
// A start pulse loads the operands; busy is high while iterating and done
// marks the final iteration, so the quotient is valid from the next cycle.
// The remainder is kept internally and not exported.
module seq_udivider #(
    parameter int DW = 64,
    parameter int VW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int            CW   = $clog2(DW + 1);
    localparam logic [CW-1:0] ITER = CW'(DW);

    logic [CW-1:0] count_r;
    logic [DW-1:0] quo_r;
    logic [VW-1:0] rem_r;
    logic [VW-1:0] den_r;
    logic [VW:0]   trial;
    logic [VW-1:0] diff;
    logic          take;

    // one restoring step: shift the next dividend bit in, subtract if it fits
    always_comb begin
        trial = {rem_r, quo_r[DW-1]};
        take  = (trial >= {1'b0, den_r});
        diff  = trial[VW-1:0] - den_r;
    end

    // operand load on start, then one quotient bit per cycle until count runs out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            den_r   <= '0;
        end else if (start) begin
            count_r <= ITER;
            quo_r   <= dividend;
            rem_r   <= '0;
            den_r   <= divisor;
        end else if (count_r != '0) begin
            count_r <= count_r - CW'(1);
            quo_r   <= {quo_r[DW-2:0], take};
            rem_r   <= take ? diff : trial[VW-1:0];
        end
    end

    assign busy     = (count_r != '0);
    assign done     = (count_r == CW'(1));
    assign quotient = quo_r;

endmodule

// File: rtl/energy_window_ctrl.sv
// Windowed-energy controller: opens/closes integrator windows of
// window_len counted samples, captures the integrated energy and divides it
// by the sample count to produce a signed mean, one result per window.
// Build option: define ENERGY_AVG_ROUND_EN to round the mean half away from
// zero instead of truncating toward zero.
module energy_window_ctrl
    import energy_pkg::*;
#(
    parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
    parameter int OUT_DATA_WIDTH = OUT_DATA_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [REG_DATA_WIDTH-1:0] window_len,
    input  logic                      in_data_valid,
    output logic                      int_start,
    output logic                      int_stop,
    input  logic [OUT_DATA_WIDTH-1:0] energy_in,
    input  logic [REG_DATA_WIDTH-1:0] energy_n_in,
    input  logic                      energy_valid_in,
    output logic [OUT_DATA_WIDTH-1:0] avg_out,
    output logic [REG_DATA_WIDTH-1:0] avg_n,
    output logic                      avg_valid,
    output logic                      div_zero,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clr_overrun
);

    localparam int RW = REG_DATA_WIDTH;
    localparam int OW = OUT_DATA_WIDTH;

    win_state_t    win_state_r;
    win_state_t    win_next;
    div_state_t    div_state_r;
    div_state_t    div_next;

    logic [RW-1:0] len_r;
    logic [RW-1:0] cnt_r;
    logic          cap_cycle_r;
    logic [RW-1:0] samples_r;
    logic          neg_r;

    logic [RW-1:0] samples;
    logic          zero_samp;
    logic          div_busy;
    logic          accept;
    logic          set_ovr;
    logic          div_start;
    logic [OW-1:0] mag;
    logic [OW-1:0] dividend;
    logic          core_busy;
    logic          core_done;
    logic [OW-1:0] quotient;

    // window FSM next-state: windows run back-to-back while enable is high
    always_comb begin
        win_next = win_state_r;
        case (win_state_r)
            IDLE: begin
                if (enable) win_next = START;
                else        win_next = IDLE;
            end
            START: win_next = RUN;
            RUN: begin
                if (in_data_valid && (cnt_r == len_r - RW'(1))) win_next = STOP;
                else                                           win_next = RUN;
            end
            STOP: begin
                if (enable) win_next = START;
                else        win_next = IDLE;
            end
            default: win_next = IDLE;
        endcase
    end

    // window state, sample counter and registered start/stop pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_state_r <= IDLE;
            len_r       <= '0;
            cnt_r       <= '0;
            int_start   <= 1'b0;
            int_stop    <= 1'b0;
            cap_cycle_r <= 1'b0;
        end else begin
            win_state_r <= win_next;
            int_start   <= (win_next == START);
            int_stop    <= (win_next == STOP);
            cap_cycle_r <= (win_state_r == STOP);
            if (win_state_r == START) begin
                len_r <= (window_len == '0) ? RW'(1) : window_len;
                cnt_r <= '0;
            end else if ((win_state_r == RUN) && in_data_valid) begin
                cnt_r <= cnt_r + RW'(1);
            end
        end
    end

    // capture decision and sign-magnitude divider operands
    always_comb begin
        samples   = energy_n_in - RW'(1);
        zero_samp = (samples == '0);
        div_busy  = core_busy || (div_state_r == DIV_SIGN);
        accept    = cap_cycle_r && energy_valid_in && !div_busy;
        set_ovr   = cap_cycle_r && (!energy_valid_in || div_busy);
        div_start = accept && !zero_samp;
        if (energy_in[OW-1]) mag = OW'(0) - energy_in;
        else                 mag = energy_in;
`ifdef ENERGY_AVG_ROUND_EN
        // |energy| <= 2^(OW-1), so adding half the divisor cannot carry out
        dividend = mag + OW'(samples >> 1);
`else
        dividend = mag;
`endif
    end

    // divider FSM next-state: RUN while the core iterates, one SIGN cycle after
    always_comb begin
        div_next = div_state_r;
        case (div_state_r)
            DIV_IDLE, DIV_DONE: begin
                if (accept) div_next = zero_samp ? DIV_DONE : DIV_RUN;
                else        div_next = DIV_IDLE;
            end
            DIV_RUN: begin
                if (core_done) div_next = DIV_SIGN;
                else           div_next = DIV_RUN;
            end
            DIV_SIGN: div_next = DIV_DONE;
            default:  div_next = DIV_IDLE;
        endcase
    end

    // divider state, captured window info, result registers and sticky overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state_r <= DIV_IDLE;
            samples_r   <= '0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            avg_valid   <= 1'b0;
            avg_out     <= '0;
            avg_n       <= '0;
            div_zero    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            div_state_r <= div_next;
            busy        <= (div_next == DIV_RUN) || (div_next == DIV_SIGN);
            if (accept) begin
                samples_r <= samples;
                neg_r     <= energy_in[OW-1];
            end
            if (div_state_r == DIV_SIGN) begin
                avg_valid <= 1'b1;
                avg_out   <= neg_r ? (OW'(0) - quotient) : quotient;
                avg_n     <= samples_r;
                div_zero  <= 1'b0;
            end else if (accept && zero_samp) begin
                avg_valid <= 1'b1;
                avg_out   <= '0;
                avg_n     <= '0;
                div_zero  <= 1'b1;
            end else begin
                avg_valid <= 1'b0;
            end
            if (set_ovr)          overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    seq_udivider #(
        .DW (OW),
        .VW (RW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (samples),
        .busy     (core_busy),
        .done     (core_done),
        .quotient (quotient)
    );

endmodule

// File: tb/tb_energy_window_ctrl.sv
// Directed plus randomized bench for energy_window_ctrl. The bench plays
// the integrator, derives window timing by counting the valid samples it
// drives, and computes expected means with plain integer arithmetic.
`timescale 1ns/1ps
module tb_energy_window_ctrl;

    localparam int RW = 32;
    localparam int OW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [RW-1:0] window_len;
    logic          in_data_valid;
    logic          int_start;
    logic          int_stop;
    logic [OW-1:0] energy_in;
    logic [RW-1:0] energy_n_in;
    logic          energy_valid_in;
    logic [OW-1:0] avg_out;
    logic [RW-1:0] avg_n;
    logic          avg_valid;
    logic          div_zero;
    logic          busy;
    logic          overrun;
    logic          clr_overrun;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always #5 clk = ~clk;

    energy_window_ctrl #(.REG_DATA_WIDTH(RW), .OUT_DATA_WIDTH(OW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .window_len      (window_len),
        .in_data_valid   (in_data_valid),
        .int_start       (int_start),
        .int_stop        (int_stop),
        .energy_in       (energy_in),
        .energy_n_in     (energy_n_in),
        .energy_valid_in (energy_valid_in),
        .avg_out         (avg_out),
        .avg_n           (avg_n),
        .avg_valid       (avg_valid),
        .div_zero        (div_zero),
        .busy            (busy),
        .overrun         (overrun),
        .clr_overrun     (clr_overrun)
    );

    // mean of a window: magnitude divided by samples, sign restored
    function automatic longint ref_avg(input longint e, input longint s);
        longint m;
        longint q;
        if (s == 0) return 0;
        m = (e < 0) ? -e : e;
`ifdef ENERGY_AVG_ROUND_EN
        m = m + s / 2;
`endif
        q = m / s;
        return (e < 0) ? -q : q;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // raise enable and wait for the window-opening pulse
    task automatic open_window(input int len);
        int k;
        window_len = RW'(len);
        enable     = 1'b1;
        k = 0;
        while (int_start !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("start_seen", int_start, 1);
    endtask

    // called in the START cycle; drives eff counted valids, ends in the STOP cycle
    task automatic fill_window(input int eff, input bit all_valid);
        int counted;
        int guard;
        bit stray;
        counted = 0;
        guard   = 0;
        stray   = 1'b0;
        in_data_valid = 1'($urandom_range(0, 1));
        while (counted < eff && guard < 400) begin
            tick();
            guard++;
            energy_valid_in = 1'b0;
            if (int_stop === 1'b1 || int_start === 1'b1) stray = 1'b1;
            if (all_valid || $urandom_range(0, 2) != 0) begin
                in_data_valid = 1'b1;
                counted++;
            end else begin
                in_data_valid = 1'b0;
            end
        end
        tick();
        energy_valid_in = 1'b0;
        check("pulse_stray", stray, 0);
        check("stop_timing", int_stop, 1);
        in_data_valid = 1'($urandom_range(0, 1));
    endtask

    // move to the capture cycle and present the integrator result there only
    task automatic capture(input longint e, input logic [RW-1:0] n, input logic exp_start, output int cap);
        tick();
        cap = cyc;
        check("start_b2b", int_start, exp_start);
        in_data_valid   = 1'b0;
        energy_valid_in = 1'b1;
        energy_in       = e;
        energy_n_in     = n;
    endtask

    task automatic wait_result(input int cap, input int exp_lat, input longint exp_avg,
                               input logic [RW-1:0] exp_n, input logic exp_dz);
        int guard;
        bit busy_bad;
        guard    = 0;
        busy_bad = 1'b0;
        while (avg_valid !== 1'b1 && guard < 200) begin
            tick();
            guard++;
            energy_valid_in = 1'b0;
            energy_in       = {$urandom(), $urandom()};
            energy_n_in     = $urandom();
            if (avg_valid !== 1'b1 && busy !== (exp_lat > 1)) busy_bad = 1'b1;
        end
        check("avg_latency", 64'(cyc - cap), 64'(exp_lat));
        check("avg_out", avg_out, exp_avg);
        check("avg_n", avg_n, exp_n);
        check("div_zero", div_zero, exp_dz);
        check("busy_window", busy_bad, 0);
        check("busy_end", busy, 0);
        tick();
        check("avg_pulse", avg_valid, 0);
        check("avg_hold", avg_out, exp_avg);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     cap;
        int     cap1;
        int     len;
        int     eff;
        longint e;
        longint s;
        logic [RW-1:0] n;
        bit     seen;

        rst = 1'b1; enable = 1'b0; window_len = '0; in_data_valid = 1'b0;
        energy_in = '0; energy_n_in = '0; energy_valid_in = 1'b0; clr_overrun = 1'b0;
        tick();
        tick();
        check("rst_ctrl", {int_start, int_stop, avg_valid, div_zero, busy, overrun}, 0);
        check("rst_avg_out", avg_out, 0);
        check("rst_avg_n", avg_n, 0);
        rst = 1'b0;
        tick();
        check("idle_no_start", int_start, 0);

        // four-sample window, energy 12
        open_window(4);
        fill_window(4, 1'b0);
        enable = 1'b0;
        capture(64'sd12, 32'd5, 1'b0, cap);
        wait_result(cap, 66, ref_avg(12, 4), 32'd4, 1'b0);

        // signed energy, two samples
        open_window(2);
        fill_window(2, 1'b0);
        enable = 1'b0;
        capture(-64'sd7, 32'd3, 1'b0, cap);
        wait_result(cap, 66, ref_avg(-7, 2), 32'd2, 1'b0);

        // zero length acts as one
        open_window(0);
        fill_window(1, 1'b0);
        enable = 1'b0;
        capture(64'sd5, 32'd2, 1'b0, cap);
        wait_result(cap, 66, ref_avg(5, 1), 32'd1, 1'b0);

        // back-to-back windows of 10: second capture meets a busy divider
        open_window(10);
        fill_window(10, 1'b1);
        capture(64'sd1000, 32'd11, 1'b1, cap1);
        fill_window(10, 1'b1);
        enable = 1'b0;
        capture(64'sd2000, 32'd11, 1'b0, cap);
        tick();
        energy_valid_in = 1'b0;
        check("overrun_set", overrun, 1);
        wait_result(cap1, 66, ref_avg(1000, 10), 32'd10, 1'b0);

        // reset in the middle of a division
        open_window(2);
        fill_window(2, 1'b1);
        enable = 1'b0;
        capture(64'sd999, 32'd3, 1'b0, cap);
        repeat (20) begin
            tick();
            energy_valid_in = 1'b0;
        end
        check("busy_mid_div", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", {int_start, int_stop, avg_valid, div_zero, busy, overrun}, 0);
        check("arst_avg_out", avg_out, 0);
        check("arst_avg_n", avg_n, 0);
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (avg_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("no_result_after_rst", seen, 0);

        // zero samples
        open_window(3);
        fill_window(3, 1'b0);
        enable = 1'b0;
        capture(64'sd12345, 32'd1, 1'b0, cap);
        wait_result(cap, 1, 0, 32'd0, 1'b1);

        // integrator result missing at capture, then clear
        open_window(1);
        fill_window(1, 1'b0);
        enable = 1'b0;
        tick();
        energy_valid_in = 1'b0;
        tick();
        check("overrun_novalid", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("overrun_clear", overrun, 0);

        // randomized single windows
        for (int i = 0; i < 10; i++) begin
            len = $urandom_range(0, 6);
            eff = (len == 0) ? 1 : len;
            e   = $signed({$urandom(), $urandom()}) >>> 2;
            n   = ($urandom_range(0, 4) == 0) ? 32'd1 : 32'($urandom_range(2, 100000));
            s   = longint'(n) - 1;
            open_window(len);
            fill_window(eff, 1'b0);
            enable = 1'b0;
            capture(e, n, 1'b0, cap);
            wait_result(cap, (s == 0) ? 1 : 66, ref_avg(e, s), n - 32'd1, (s == 0));
        end
        check("overrun_quiet", overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
